reorder_ctrl: RTL

REORDER_CTRL -- requirements
Module: reorder_ctrl

---
 rtl/reorder_pkg.sv | 16 +
 rtl/addr_rev_map.sv | 44 ++++
 rtl/reorder_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/reorder_pkg.sv
// Shared definitions for the re-order address controller: FSM state encoding
// and the address-map mode selectors.
package reorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WORK   = 2'd1,
        ST_WORK_F = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int REV_LINEAR = 0;
    localparam int REV_BIT    = 1;
    localparam int REV_DIGIT  = 2;

endpackage

// File: rtl/addr_rev_map.sv
// Combinational address permutation: linear, full bit-reverse, or reversal
// of the order of 4-bit (radix-16) digits.
module addr_rev_map
    import reorder_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int REV_MODE = REV_LINEAR
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rema
);

    if ((REV_MODE == REV_DIGIT) && ((ADDR_W % 4) != 0)) begin : g_bad_digit_width
        $error("addr_rev_map: digit-reverse mode needs ADDR_W to be a multiple of 4");
    end

    if ((REV_MODE < REV_LINEAR) || (REV_MODE > REV_DIGIT)) begin : g_bad_mode
        $error("addr_rev_map: unsupported REV_MODE");
    end

    // Address permutation selected by REV_MODE
    always_comb begin
        rema = addr;
        case (REV_MODE)
            REV_LINEAR: begin
                rema = addr;
            end
            REV_BIT: begin
                for (int i = 0; i < ADDR_W; i++) begin
                    rema[i] = addr[ADDR_W-1-i];
                end
            end
            REV_DIGIT: begin
                for (int d = 0; d < ADDR_W / 4; d++) begin
                    rema[4*d +: 4] = addr[ADDR_W-4-4*d +: 4];
                end
            end
            default: begin
                rema = addr;
            end
        endcase
    end

endmodule

// File: rtl/reorder_ctrl.sv
// Re-order memory read-address sequencer: walks a frame counter through
// 0..ADDR_LAST and presents it through the selected address permutation.
module reorder_ctrl
    import reorder_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int ADDR_LAST = (2 ** ADDR_W) - 1,
    parameter int REV_MODE  = REV_LINEAR,
    parameter int CONT      = 0,
    parameter int FRM_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_valid_in,
    input  logic              stall,
    input  logic              clr,
    output logic [ADDR_W-1:0] rema,
    output logic              rema_valid,
    output logic              frame_done,
    output logic              busy,
    output logic [FRM_W-1:0]  frame_cnt
);

    if ((ADDR_LAST < 0) || (ADDR_LAST > (2 ** ADDR_W) - 1)) begin : g_bad_last
        $error("reorder_ctrl: ADDR_LAST does not fit in ADDR_W bits");
    end

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ADDR_LAST);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [FRM_W-1:0]  ONE_F  = FRM_W'(1);

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  cnt_r, cnt_s;
    logic [FRM_W-1:0]   frame_cnt_r, frame_cnt_s;

    // Next-state logic; clr overrides every FSM decision
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        frame_cnt_s = frame_cnt_r;
        if (clr) begin
            state_s     = ST_IDLE;
            cnt_s       = '0;
            frame_cnt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = '0;
                    if (ext_valid_in) begin
                        state_s = ST_WORK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WORK: begin
                    if (stall) begin
                        state_s = ST_WORK;
                    end else if (cnt_r == LAST_A) begin
                        state_s = ST_WORK_F;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + ONE_A;
                    end
                end
                ST_WORK_F: begin
                    frame_cnt_s = frame_cnt_r + ONE_F;
                    if (CONT == 0) begin
                        state_s = ST_OVER;
                    end else if (ext_valid_in) begin
                        state_s = ST_WORK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_OVER: begin
                    state_s = ST_OVER;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, address counter and frame counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            frame_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    // The map sits directly on the registered counter so rema adds no latency
    addr_rev_map #(
        .ADDR_W   (ADDR_W),
        .REV_MODE (REV_MODE)
    ) u_map (
        .addr (cnt_r),
        .rema (rema)
    );

    assign rema_valid = (state_r == ST_WORK) && !stall;
    assign frame_done = (state_r == ST_WORK_F);
    assign busy       = (state_r == ST_WORK) || (state_r == ST_WORK_F);
    assign frame_cnt  = frame_cnt_r;

endmodule
